stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
- Valid/ready width downsizer. It accepts one wide word per input handshake and transmits it as RATIO consecutive narrow beats on a valid/ready output, flagging the final beat with out_last.
- It is the transmit-side complement to the team's stream buffering blocks. It sits between a wide internal datapath and a narrow AXI-Stream-style link.
- It sustains full output throughput: one narrow beat per cycle with no bubble between words.

Parameters:
- OUT_WIDTH, 8, width of one output beat in bits.
- RATIO, 4, beats per input word. Must be >= 2; elaboration fails otherwise.
- LSB_FIRST, 1'b1. When 1, beat 0 is in_data[OUT_WIDTH-1:0]. When 0, beat 0 is the most significant slice.

Ports:
- clk  input  1  Sole clock; all state updates on the rising edge.
- reset_n  input  1  Asynchronous, active-low reset.
- in_data  input  OUT_WIDTH*RATIO  Wide word to serialize.
- in_valid  input  1  Upstream word valid.
- in_ready  output  1  Serializer can accept a word this cycle.
- out_data  output  OUT_WIDTH  Current beat. Registered.
- out_valid  output  1  Beat valid. Registered.
- out_last  output  1  High on the final beat (index RATIO-1) of a word.
- out_ready  input  1  Downstream accepts the beat.

Behaviour:
- Handshake definitions:
  - rx = in_valid && in_ready.
  - tx = out_valid && out_ready.
- Reset (reset_n low, asynchronous assertion):
  - State = IDLE, beat counter = 0, out_valid = 0, in_ready = 0.
  - out_data and the shift register are don't-care.
  - A 1-bit reset_seen flag is set asynchronously by reset. It clears on the first rising edge with reset_n high.
  - in_ready is forced low while reset_seen = 1, so no word is accepted in the first cycle after deassertion.
- States (2): IDLE (no word held) and SEND (word held, beats pending).
- Beat counter: width $clog2(RATIO), counts 0..RATIO-1.
- in_ready (combinational):
  - Equals !reset_seen && (state == IDLE || (tx && counter == RATIO-1)).
  - The dependency on out_ready is intentional, to allow back-to-back words.
- IDLE:
  - out_valid = 0.
  - On rx: load the shift register with in_data, drive beat 0 onto out_data, set counter = 0, go to SEND.
  - Latency from input handshake to out_valid is 1 cycle.
- SEND, out_valid = 1:
  - No tx: out_data, out_last, counter and the shift register are held stable (protocol stability rule).
  - tx with counter < RATIO-1: advance to the next slice, counter + 1.
  - tx with counter == RATIO-1 and no rx: go to IDLE, out_valid = 0 next cycle.
  - tx with counter == RATIO-1 and simultaneous rx: load the new word, drive its beat 0, counter = 0, stay in SEND. There is no bubble.
- out_last is registered and high exactly when out_valid && counter == RATIO-1.
- Ordering: for LSB_FIRST = 1, beat k = in_data[k*OUT_WIDTH +: OUT_WIDTH]. For LSB_FIRST = 0, beat k = in_data[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH].
- Data integrity: beats are never dropped, duplicated or reordered. Words are never interleaved.
- Counting invariant: (narrow tx count) = RATIO*(wide rx count) - (beats remaining in current word).
- in_valid deasserted mid-word has no effect. Only rx events load.
- Reset mid-word: the word is discarded immediately, and out_valid drops asynchronously.
- Formal properties, under `ifdef FORMAL`:
  - state is legal.
  - The counter is never > RATIO-1.
  - out_data and out_last are stable while out_valid && !out_ready.
  - in_ready is low while reset_seen is high.
  - The counting invariant above holds.
  - For an anyconst word index, all RATIO beats match the captured word in order.

Test Plan:
- Reset: hold reset_n low 3 cycles with in_valid = 1, then release. in_ready = 0, out_valid = 0 through the first post-reset cycle; in_ready = 1 on the second.
- Single word, OUT_WIDTH=8, RATIO=4, LSB_FIRST=1, in_data = 32'hA1B2C3D4, out_ready = 1. Beats D4, C3, B2, A1 on 4 consecutive cycles starting 1 cycle after rx; out_last only with A1; then out_valid = 0.
- Back-to-back: words 32'h03020100 and 32'h07060504 offered continuously, out_ready = 1. 8 consecutive beats 00..07 with no gap; in_ready pulses high on the cycle beat 03 transfers.
- Backpressure: out_ready low for 3 cycles on beat 1 of 32'h11223344. out_data holds 8'h33 and out_last = 0 for all stalled cycles; sequence resumes 22, 11.
- MSB-first: LSB_FIRST = 0, in_data = 32'hA1B2C3D4. Beats A1, B2, C3, D4; out_last with D4.
- Reset mid-word: assert reset_n low after beat 1 of a word is sent. out_valid falls asynchronously; after release, the next word starts cleanly at beat 0 with counter = 0.

Source files
------------

// File: rtl/stream_serializer.sv
// Valid/ready width downsizer: one wide word in, RATIO narrow beats out,
// with out_last on the final beat and no bubble between back-to-back words.
module stream_serializer #(
   parameter int OUT_WIDTH = 8,
   parameter int RATIO     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [OUT_WIDTH*RATIO-1:0] in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [OUT_WIDTH-1:0]       out_data,
   output logic                       out_valid,
   output logic                       out_last,
   input  logic                       out_ready
);
   localparam int IN_WIDTH = OUT_WIDTH * RATIO;
   localparam int CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

   if (RATIO < 2) begin : g_ratio_check
      $error("stream_serializer: RATIO must be at least 2");
   end

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   function automatic logic [OUT_WIDTH-1:0] head_beat(input logic [IN_WIDTH-1:0] word);
      if (LSB_FIRST) head_beat = word[OUT_WIDTH-1:0];
      else           head_beat = word[IN_WIDTH-1 -: OUT_WIDTH];
   endfunction

   function automatic logic [IN_WIDTH-1:0] drop_beat(input logic [IN_WIDTH-1:0] word);
      if (LSB_FIRST) drop_beat = word >> OUT_WIDTH;
      else           drop_beat = word << OUT_WIDTH;
   endfunction

   state_t                 state_r, state_nx;
   logic [CNT_W-1:0]       cnt_r, cnt_nx;
   logic [IN_WIDTH-1:0]    shift_r, shift_nx, shifted_s;
   logic [OUT_WIDTH-1:0]   out_data_r, out_data_nx;
   logic                   out_valid_r, out_valid_nx;
   logic                   out_last_r, out_last_nx;
   logic                   reset_seen_r;
   logic                   tx_s, rx_s, last_s, in_ready_s;

   // Next-state, handshake and beat-selection logic.
   always_comb begin
      tx_s         = out_valid_r && out_ready;
      last_s       = (cnt_r == LAST_BEAT);
      in_ready_s   = !reset_seen_r && ((state_r == IDLE) || (tx_s && last_s));
      rx_s         = in_valid && in_ready_s;
      shifted_s    = drop_beat(shift_r);
      state_nx     = state_r;
      cnt_nx       = cnt_r;
      shift_nx     = shift_r;
      out_data_nx  = out_data_r;
      out_valid_nx = out_valid_r;
      out_last_nx  = out_last_r;
      // in_ready is only high in IDLE or on the last beat's transfer, so rx always means "load"
      if (rx_s) begin
         state_nx     = SEND;
         cnt_nx       = {CNT_W{1'b0}};
         shift_nx     = in_data;
         out_data_nx  = head_beat(in_data);
         out_valid_nx = 1'b1;
         out_last_nx  = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               out_valid_nx = 1'b0;
               out_last_nx  = 1'b0;
            end
            SEND: begin
               if (tx_s) begin
                  if (last_s) begin
                     state_nx     = IDLE;
                     out_valid_nx = 1'b0;
                     out_last_nx  = 1'b0;
                  end else begin
                     cnt_nx      = cnt_r + CNT_W'(1);
                     shift_nx    = shifted_s;
                     out_data_nx = head_beat(shifted_s);
                     out_last_nx = (cnt_nx == LAST_BEAT);
                  end
               end else begin
                  state_nx = SEND;
               end
            end
            default: begin
               state_nx     = IDLE;
               cnt_nx       = {CNT_W{1'b0}};
               out_valid_nx = 1'b0;
               out_last_nx  = 1'b0;
            end
         endcase
      end
   end

   // State, beat and output registers; reset_seen blocks acceptance for one cycle after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         shift_r      <= {IN_WIDTH{1'b0}};
         out_data_r   <= {OUT_WIDTH{1'b0}};
         out_valid_r  <= 1'b0;
         out_last_r   <= 1'b0;
         reset_seen_r <= 1'b1;
      end else begin
         state_r      <= state_nx;
         cnt_r        <= cnt_nx;
         shift_r      <= shift_nx;
         out_data_r   <= out_data_nx;
         out_valid_r  <= out_valid_nx;
         out_last_r   <= out_last_nx;
         reset_seen_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;

`ifdef FORMAL
   stream_serializer_props #(
      .OUT_WIDTH(OUT_WIDTH), .RATIO(RATIO), .LSB_FIRST(LSB_FIRST), .CNT_W(CNT_W)
   ) u_props (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_s), .out_data(out_data_r), .out_valid(out_valid_r),
      .out_last(out_last_r), .out_ready(out_ready), .send(state_r == SEND),
      .state_ok((state_r == IDLE) || (state_r == SEND)), .cnt(cnt_r),
      .reset_seen(reset_seen_r)
   );
`endif
endmodule

`ifdef FORMAL
// Property checker: protocol stability, beat accounting and word-order integrity.
module stream_serializer_props #(
   parameter int OUT_WIDTH = 8,
   parameter int RATIO     = 4,
   parameter bit LSB_FIRST = 1'b1,
   parameter int CNT_W     = 2
) (
   input logic                       clk,
   input logic                       reset_n,
   input logic [OUT_WIDTH*RATIO-1:0] in_data,
   input logic                       in_valid,
   input logic                       in_ready,
   input logic [OUT_WIDTH-1:0]       out_data,
   input logic                       out_valid,
   input logic                       out_last,
   input logic                       out_ready,
   input logic                       send,
   input logic                       state_ok,
   input logic [CNT_W-1:0]           cnt,
   input logic                       reset_seen
);
   (* anyconst *) logic [31:0] pick_idx;
   logic [31:0]                rx_cnt_r, tx_cnt_r, beat_k_s, remaining_s;
   logic [OUT_WIDTH*RATIO-1:0] pick_word_r;
   logic                       pick_seen_r;

   // Running handshake counts and capture of the chosen word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_cnt_r    <= 32'd0;
         tx_cnt_r    <= 32'd0;
         pick_word_r <= '0;
         pick_seen_r <= 1'b0;
      end else begin
         if (in_valid && in_ready) rx_cnt_r <= rx_cnt_r + 32'd1;
         else                      rx_cnt_r <= rx_cnt_r;
         if (out_valid && out_ready) tx_cnt_r <= tx_cnt_r + 32'd1;
         else                        tx_cnt_r <= tx_cnt_r;
         if (in_valid && in_ready && (rx_cnt_r == pick_idx)) begin
            pick_word_r <= in_data;
            pick_seen_r <= 1'b1;
         end else begin
            pick_word_r <= pick_word_r;
            pick_seen_r <= pick_seen_r;
         end
      end
   end

   assign remaining_s = send ? (32'(RATIO) - 32'(cnt)) : 32'd0;
   assign beat_k_s    = tx_cnt_r - (32'(RATIO) * pick_idx);

   // Immediate property checks evaluated every cycle out of reset.
   always @(posedge clk) begin
      if (reset_n) begin
         assert (state_ok);
         assert (32'(cnt) <= 32'(RATIO - 1));
         assert (out_last == (out_valid && (32'(cnt) == 32'(RATIO - 1))));
         assert (!(reset_seen && in_ready));
         assert (tx_cnt_r == (32'(RATIO) * rx_cnt_r) - remaining_s);
         if ($past(reset_n) && $past(out_valid && !out_ready)) begin
            assert (out_valid && (out_data == $past(out_data)) && (out_last == $past(out_last)));
         end
         if (pick_seen_r && out_valid && (tx_cnt_r >= 32'(RATIO) * pick_idx) && (beat_k_s < 32'(RATIO))) begin
            if (LSB_FIRST) assert (out_data == pick_word_r[beat_k_s*OUT_WIDTH +: OUT_WIDTH]);
            else           assert (out_data == pick_word_r[(32'(RATIO) - 32'd1 - beat_k_s)*OUT_WIDTH +: OUT_WIDTH]);
         end
      end
   end
endmodule
`endif

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: an LSB-first and an MSB-first instance,
// scoreboard queues filled on each accepted word and drained on each sent beat.
module tb_stream_serializer;
   logic        clk, reset_n;
   logic [31:0] in_data, m_in_data;
   logic        in_valid, in_ready, m_in_valid, m_in_ready;
   logic [7:0]  out_data, m_out_data;
   logic        out_valid, out_last, out_ready;
   logic        m_out_valid, m_out_last, m_out_ready;

   int n_checks = 0;
   int n_pass   = 0;
   logic [8:0] sb_q[$];
   logic [8:0] msb_q[$];
   logic [8:0] e_l, e_m;

   logic [7:0] t_single[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
   logic [7:0] t_msb[4]    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
   logic [7:0] t_rst[4]    = '{8'hCC, 8'hBB, 8'hAA, 8'h99};

   stream_serializer #(.OUT_WIDTH(8), .RATIO(4), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready)
   );

   stream_serializer #(.OUT_WIDTH(8), .RATIO(4), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .reset_n(reset_n), .in_data(m_in_data), .in_valid(m_in_valid),
      .in_ready(m_in_ready), .out_data(m_out_data), .out_valid(m_out_valid),
      .out_last(m_out_last), .out_ready(m_out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [8:0] beat_of(input logic [31:0] w, input int k, input bit lsb);
      int s;
      s = lsb ? k : 3 - k;
      return {(k == 3), w[s*8 +: 8]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!out_valid && !m_out_valid) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, 64'(done), 64'd1);
   endtask

   // Scoreboard: pop on each beat transfer, push the four expected beats on each accepted word.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("lsb_extra_beat", 64'(sb_q.size()), 64'd1);
         else begin
            e_l = sb_q.pop_front();
            chk("lsb_beat", 64'({out_last, out_data}), 64'(e_l));
         end
      end
      if (reset_n && in_valid && in_ready)
         for (int k = 0; k < 4; k++) sb_q.push_back(beat_of(in_data, k, 1'b1));
      if (reset_n && m_out_valid && m_out_ready) begin
         if (msb_q.size() == 0) chk("msb_extra_beat", 64'(msb_q.size()), 64'd1);
         else begin
            e_m = msb_q.pop_front();
            chk("msb_beat", 64'({m_out_last, m_out_data}), 64'(e_m));
         end
      end
      if (reset_n && m_in_valid && m_in_ready)
         for (int k = 0; k < 4; k++) msb_q.push_back(beat_of(m_in_data, k, 1'b0));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b1;
      in_data     = 32'hDEADBEEF;
      out_ready   = 1'b1;
      m_in_valid  = 1'b0;
      m_in_data   = 32'h0;
      m_out_ready = 1'b1;

      // Reset held three cycles with in_valid high
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst1_in_ready", 64'(in_ready), 64'd0);
      chk("post_rst1_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("post_rst2_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst2_out_valid", 64'(out_valid), 64'd0);
      step();
      in_valid = 1'b0;
      wait_idle("drain_reset_word");

      // Single word, LSB first
      step();
      in_valid = 1'b1;
      in_data  = 32'hA1B2C3D4;
      @(negedge clk);
      chk("single_in_ready", 64'(in_ready), 64'd1);
      chk("single_latency", 64'(out_valid), 64'd0);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("single_valid%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("single_data%0d", k), 64'(out_data), 64'(t_single[k]));
         chk($sformatf("single_last%0d", k), 64'(out_last), 64'(k == 3));
         step();
      end
      @(negedge clk);
      chk("single_idle", 64'(out_valid), 64'd0);

      // Back-to-back words, no bubble
      step();
      in_valid = 1'b1;
      in_data  = 32'h03020100;
      step();
      in_data  = 32'h07060504;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("b2b_valid%0d", c), 64'(out_valid), 64'd1);
         chk($sformatf("b2b_data%0d", c), 64'(out_data), 64'(c));
         chk($sformatf("b2b_in_ready%0d", c), 64'(in_ready), 64'((c == 3) || (c == 7)));
         step();
         if (c == 3) in_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_idle", 64'(out_valid), 64'd0);

      // Backpressure on beat 1
      step();
      in_valid = 1'b1;
      in_data  = 32'h11223344;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_beat0", 64'(out_data), 64'h44);
      step();
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_data%0d", s), 64'(out_data), 64'h33);
         chk($sformatf("bp_hold_last%0d", s), 64'(out_last), 64'd0);
         chk($sformatf("bp_hold_valid%0d", s), 64'(out_valid), 64'd1);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_beat1", 64'(out_data), 64'h33);
      step();
      @(negedge clk);
      chk("bp_beat2", 64'(out_data), 64'h22);
      step();
      @(negedge clk);
      chk("bp_beat3", 64'({out_last, out_data}), 64'h111);
      wait_idle("bp_drain");

      // MSB-first instance
      step();
      m_in_valid = 1'b1;
      m_in_data  = 32'hA1B2C3D4;
      step();
      m_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("msb_data%0d", k), 64'(m_out_data), 64'(t_msb[k]));
         chk($sformatf("msb_last%0d", k), 64'(m_out_last), 64'(k == 3));
         step();
      end
      wait_idle("msb_drain");

      // Reset asserted after beat 1 of a word has transferred
      step();
      in_valid = 1'b1;
      in_data  = 32'h55667788;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_beat0", 64'(out_data), 64'h88);
      step();
      @(negedge clk);
      chk("mid_beat1", 64'(out_data), 64'h77);
      step();
      reset_n = 1'b0;
      #1;
      chk("mid_async_valid", 64'(out_valid), 64'd0);
      chk("mid_async_in_ready", 64'(in_ready), 64'd0);
      sb_q.delete();
      msb_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("mid_post_in_ready", 64'(in_ready), 64'd0);
      chk("mid_post_valid", 64'(out_valid), 64'd0);
      step();
      in_valid = 1'b1;
      in_data  = 32'h99AABBCC;
      @(negedge clk);
      chk("mid_restart_in_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("mid_data%0d", k), 64'(out_data), 64'(t_rst[k]));
         chk($sformatf("mid_last%0d", k), 64'(out_last), 64'(k == 3));
         step();
      end
      wait_idle("mid_drain");

      chk("lsb_sb_empty", 64'(sb_q.size()), 64'd0);
      chk("msb_sb_empty", 64'(msb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
